// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path (i2s_tx and its feed stage).
package i2s_pkg;

    localparam int I2S_WIDTH      = 32;
    localparam int I2S_SCLK_DIV   = 4;
    localparam int I2S_FIFO_DEPTH = 4;

    localparam logic I2S_SLOT_LEFT  = 1'b0;
    localparam logic I2S_SLOT_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_tx_feed_if.sv
// Valid/ready stereo frame stream feeding i2s_tx_feed.
interface i2s_tx_feed_if #(
    parameter int WIDTH = i2s_pkg::I2S_WIDTH
);

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_ldata;
    logic [WIDTH-1:0] s_rdata;

    modport master (output s_valid, output s_ldata, output s_rdata, input s_ready);
    modport slave  (input s_valid, input s_ldata, input s_rdata, output s_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap by natural binary overflow since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_feed.sv
// I2S feed: sclk/lrck generation plus a frame FIFO presented once per lrck period.
// Optional I2S_TX_FEED_MUTE_EN: outputs are zeroed on underrun instead of repeating the last frame.
module i2s_tx_feed
    import i2s_pkg::*;
#(
    parameter int WIDTH      = I2S_WIDTH,
    parameter int SCLK_DIV   = I2S_SCLK_DIV,
    parameter int FIFO_DEPTH = I2S_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    i2s_tx_feed_if.slave     s,
    output logic             sclk,
    output logic             lrck,
    output logic [WIDTH-1:0] pldout,
    output logic [WIDTH-1:0] prdout,
    output logic             underrun
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               div_last;
    logic               bit_last;
    logic               fall_evt;
    logic               frame_evt;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] head_q;

    assign div_last  = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign bit_last  = (bit_cnt == BIT_W'(WIDTH - 1));
    assign fall_evt  = div_last && sclk;
    assign frame_evt = fall_evt && bit_last && (lrck == I2S_SLOT_RIGHT);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_last) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Slot boundaries ride on sclk falling edges so lrck never moves mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            lrck    <= I2S_SLOT_LEFT;
        end else if (fall_evt) begin
            if (bit_last) begin
                bit_cnt <= '0;
                lrck    <= (lrck == I2S_SLOT_LEFT) ? I2S_SLOT_RIGHT : I2S_SLOT_LEFT;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign s.s_ready = !fifo_full;
    assign push      = s.s_valid && !fifo_full;
    assign pop       = frame_evt && !fifo_empty;

    sync_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({s.s_ldata, s.s_rdata}),
        .rd_en   (pop),
        .rd_data (head_q),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= frame_evt && fifo_empty;
        end
    end

`ifdef I2S_TX_FEED_MUTE_EN
    logic muted;

    // The FIFO read register keeps the old frame on underrun, so muting masks it until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            muted <= 1'b0;
        end else if (frame_evt) begin
            muted <= fifo_empty;
        end
    end

    assign {pldout, prdout} = muted ? '0 : head_q;
`else
    assign {pldout, prdout} = head_q;
`endif

endmodule

// File: doc/i2s_tx_feed.md
Name: i2s_tx_feed

Overview:
Upstream stage of the I2S transmitter. It generates the sclk and lrck bit and frame clocks from the system clock. It buffers stereo frames pushed with a valid/ready handshake and presents one frame per I2S period on the transmitter's parallel left/right inputs. An empty buffer at a frame boundary is reported as an underrun.

Parameters:
WIDTH, 32, bits per channel slot; equals the transmitter's WIDTH
SCLK_DIV, 4, clk cycles per sclk half-period (>=1); sclk period = 2*SCLK_DIV clk
FIFO_DEPTH, 4, stereo frames buffered; power of two, >=2

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
s_valid  in  1  upstream frame valid
s_ready  out  1  buffer can accept a frame
s_ldata  in  WIDTH  left sample of pushed frame
s_rdata  in  WIDTH  right sample of pushed frame
sclk  out  1  I2S bit clock (registered)
lrck  out  1  I2S word clock (registered); 0 = left slot, 1 = right slot
pldout  out  WIDTH  left sample to transmitter pldin
prdout  out  WIDTH  right sample to transmitter prdin
underrun  out  1  one-clk pulse: buffer empty at frame start

Behaviour:
- Reset values: sclk=0, lrck=0, pldout=0, prdout=0, underrun=0, s_ready=1. div_cnt=0, bit_cnt=0, FIFO empty (count=0, pointers 0). Reset mid-operation discards all buffered frames.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1.
  - At SCLK_DIV-1: div_cnt<=0 and sclk toggles.
  - fall_evt = (div_cnt==SCLK_DIV-1) && sclk==1, i.e. the clk cycle that drives sclk 1->0.
- Bit counter:
  - On fall_evt, bit_cnt increments.
  - If bit_cnt==WIDTH-1 on fall_evt: bit_cnt<=0 and lrck toggles.
  - lrck changes only coincident with sclk falling; each slot lasts exactly WIDTH sclk periods.
- frame_evt = fall_evt && bit_cnt==WIDTH-1 && lrck==1, i.e. the lrck 1->0 transition.
- On the clk cycle of frame_evt:
  - FIFO non-empty: pop head; pldout/prdout <= head {left,right} on the same edge.
  - FIFO empty: pldout/prdout hold their previous values; underrun=1 for exactly that cycle.
- pldout/prdout change only at frame_evt, so they are stable across both transmitter loads of the frame (left load ~1.5 sclk after lrck fall, right load ~1.5 sclk after lrck rise).
- First frame_evt after reset occurs after 2*WIDTH sclk periods. The first transmitted frame is therefore all-zero; this is intentional.
- FIFO:
  - Storage is 2*WIDTH bits wide, FIFO_DEPTH entries.
  - Push when s_valid && s_ready.
  - s_ready = (count != FIFO_DEPTH), combinational from registered count.
  - Push and pop in the same cycle: count unchanged; both pointers advance modulo FIFO_DEPTH.
  - Push into an empty FIFO on the frame_evt cycle: no bypass. Pop sees empty, underrun fires, and the frame is stored for the next frame.
  - When full, s_ready=0 and upstream holds. A pop in that cycle does not admit a push in the same cycle.
  - Pointer wrap is natural binary overflow; count ranges 0..FIFO_DEPTH.
- s_ldata/s_rdata are sampled only on an accepted push.

Optional Feature:
- Macro: I2S_TX_FEED_MUTE_EN.
- Defined: on underrun at frame_evt, pldout/prdout <= 0 (mute); the underrun pulse is unchanged.
- Undefined: last frame repeats on underrun, as specified above.

Decomposition:
- Package i2s_pkg:
  - localparam defaults I2S_WIDTH=32, I2S_SCLK_DIV=4, I2S_FIFO_DEPTH=4.
  - Slot encoding constants I2S_SLOT_LEFT=0, I2S_SLOT_RIGHT=1.
  - Shared by i2s_tx and this block.
- Sub-module sync_fifo:
  - Parameters DATA_W, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data (registered on rd_en), full, empty.
  - Instantiated with DATA_W=2*WIDTH.
- Clock/counter logic stays in i2s_tx_feed.

Test Plan:
- Reset then idle (WIDTH=32, SCLK_DIV=4): sclk period 8 clk. lrck first rises at clk 256 and first falls at clk 512. Underrun pulses at clk 512; pldout/prdout stay 0.
- Push {L=32'hA5A5_0001, R=32'h5A5A_0002} before first frame_evt: at frame_evt, pldout=A5A50001 and prdout=5A5A0002, no underrun. Values held for 2*WIDTH sclk periods.
- Push 5 frames back-to-back with FIFO_DEPTH=4: s_ready drops after 4 accepts and reasserts the cycle after the next pop. Frames emerge in push order, one per frame_evt.
- Push on exactly the frame_evt cycle into an empty FIFO: underrun pulses, old data held. The pushed frame appears at the following frame_evt.
- Assert rst mid-slot with 3 frames queued: next cycle sclk=0, lrck=0, outputs 0, s_ready=1. Queued frames are never emitted.
- With I2S_TX_FEED_MUTE_EN defined: after one frame {1,2}, let FIFO drain. Next frame_evt gives pldout=prdout=0 with an underrun pulse. Without the macro, the outputs stay {1,2}.
